// File: rtl/alu_pipe_if.sv
// Handshake bundle between the ID/EX stage and alu_pipe.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_pipe_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
);
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [SHAMT_W-1:0] shamt;
    logic [3:0]         aluctrl;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    aluout;
    logic               overflow;
    logic               zero;
    logic               lt;
    logic               ge;
    logic               busy;

    modport master (
        output in_valid, a, b, shamt, aluctrl, out_ready,
        input  in_ready, out_valid, aluout, overflow, zero, lt, ge, busy
    );

    modport slave (
        input  in_valid, a, b, shamt, aluctrl, out_ready,
        output in_ready, out_valid, aluout, overflow, zero, lt, ge, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined RV32I/RV64I ALU with a registered valid/ready result stage.
// Define XGRISCV_ALU_MUL_EN to build the iterative radix-2 multiplier for aluctrl 1111.
module alu_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input logic       clk,
    input logic       rstn,
    alu_pipe_if.slave bus
);
    localparam logic [3:0] OpAdd   = 4'b0000;
    localparam logic [3:0] OpSub   = 4'b1000;
    localparam logic [3:0] OpAddu  = 4'b0010;
    localparam logic [3:0] OpSubu  = 4'b1010;
    localparam logic [3:0] OpSlt   = 4'b1101;
    localparam logic [3:0] OpSltu  = 4'b1100;
    localparam logic [3:0] OpMovea = 4'b0001;
    localparam logic [3:0] OpAnd   = 4'b0101;
    localparam logic [3:0] OpOr    = 4'b0110;
    localparam logic [3:0] OpXor   = 4'b0111;
    localparam logic [3:0] OpSll   = 4'b0011;
    localparam logic [3:0] OpSrl   = 4'b1001;
    localparam logic [3:0] OpSra   = 4'b1011;
    localparam logic [3:0] OpZero  = 4'b1110;
    localparam logic [3:0] OpRsvd  = 4'b0100;
    localparam logic [3:0] OpMul   = 4'b1111;

    logic               out_valid_q;
    logic [XLEN-1:0]    aluout_q;
    logic               overflow_q;
    logic               zero_q;
    logic               lt_q;
    logic               ge_q;
    logic               busy;
    logic               in_ready;
    logic               accept;

    logic [SHAMT_W-1:0] shamt;
    logic               sub_op;
    logic               signed_op;
    logic               cmp_op;
    logic [XLEN:0]      ext_a;
    logic [XLEN:0]      ext_b;
    logic [XLEN:0]      sum;
    logic [XLEN-1:0]    res;
    logic               res_ovf;
    logic               res_lt;

    assign shamt     = bus.shamt;
    assign in_ready  = ~busy & (~out_valid_q | bus.out_ready);
    assign accept    = bus.in_valid & in_ready;

    // Shared XLEN+1 bit adder; the extension bit carries sign, carry or borrow.
    assign sub_op    = bus.aluctrl[3];
    assign signed_op = (bus.aluctrl == OpAdd) || (bus.aluctrl == OpSub);
    assign cmp_op    = (bus.aluctrl == OpSlt) || (bus.aluctrl == OpSltu);
    assign ext_a     = {signed_op & bus.a[XLEN-1], bus.a};
    assign ext_b     = {signed_op & bus.b[XLEN-1], bus.b};
    assign sum       = ext_a + (sub_op ? ~ext_b : ext_b) + {{XLEN{1'b0}}, sub_op};

    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        case (bus.aluctrl)
            OpAdd, OpSub: begin
                res     = sum[XLEN-1:0];
                res_ovf = sum[XLEN] ^ sum[XLEN-1];
            end
            OpAddu, OpSubu: begin
                res     = sum[XLEN-1:0];
                res_ovf = sum[XLEN];
            end
            OpSlt:   res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OpSltu:  res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            OpMovea: res = bus.a;
            OpAnd:   res = bus.a & bus.b;
            OpOr:    res = bus.a | bus.b;
            OpXor:   res = bus.a ^ bus.b;
            OpSll:   res = bus.a << shamt;
            OpSrl:   res = bus.a >> shamt;
            OpSra:   res = $unsigned($signed(bus.a) >>> shamt);
            OpZero, OpRsvd, OpMul: res = '0;
            default: res = '0;
        endcase
        res_lt = cmp_op ? res[0] : res[XLEN-1];
    end

`ifdef XGRISCV_ALU_MUL_EN
    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e          state_q;
    logic            busy_q;
    logic [XLEN-1:0] mul_a_q;
    logic [XLEN-1:0] mul_b_q;
    logic [XLEN-1:0] acc_q;
    logic [CntW-1:0] cnt_q;
    logic [XLEN-1:0] acc_next;
    logic            mul_last;
    logic            mul_done;

    assign busy     = busy_q;
    assign acc_next = acc_q + (mul_b_q[0] ? mul_a_q : '0);
    assign mul_last = (state_q == StMul) && (cnt_q == CntW'(XLEN - 1));
    // The final step waits rather than overwrite an unconsumed result.
    assign mul_done = mul_last & (~out_valid_q | bus.out_ready);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            aluout_q    <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            lt_q        <= 1'b0;
            ge_q        <= 1'b1;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (state_q == StIdle) begin
                if (accept && (bus.aluctrl == OpMul)) begin
                    state_q <= StMul;
                    busy_q  <= 1'b1;
                    mul_a_q <= bus.a;
                    mul_b_q <= bus.b;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                end else if (accept) begin
                    out_valid_q <= 1'b1;
                    aluout_q    <= res;
                    overflow_q  <= res_ovf;
                    zero_q      <= (res == '0);
                    lt_q        <= res_lt;
                    ge_q        <= ~res_lt;
                end
            end else if (!mul_last) begin
                acc_q   <= acc_next;
                mul_a_q <= mul_a_q << 1;
                mul_b_q <= mul_b_q >> 1;
                cnt_q   <= cnt_q + CntW'(1);
            end else if (mul_done) begin
                state_q     <= StIdle;
                busy_q      <= 1'b0;
                out_valid_q <= 1'b1;
                aluout_q    <= acc_next;
                overflow_q  <= 1'b0;
                zero_q      <= (acc_next == '0);
                lt_q        <= acc_next[XLEN-1];
                ge_q        <= ~acc_next[XLEN-1];
            end
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            aluout_q    <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            lt_q        <= 1'b0;
            ge_q        <= 1'b1;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            aluout_q    <= res;
            overflow_q  <= res_ovf;
            zero_q      <= (res == '0);
            lt_q        <= res_lt;
            ge_q        <= ~res_lt;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.aluout    = aluout_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.lt        = lt_q;
    assign bus.ge        = ge_q;
    assign bus.busy      = busy;
endmodule
